// File: rtl/jelly_rtos_flggrp_if.sv
// rtl/jelly_rtos_flggrp_if.sv - request/response bundle for the jelly_rtos_flggrp event-flag group
interface jelly_rtos_flggrp_if #(
    parameter int TASKS        = 16,
    parameter int FLAGS        = 4,
    parameter int FLGPTN_WIDTH = 32,
    parameter int TSKID_WIDTH  = $clog2(TASKS),
    parameter int FLGID_WIDTH  = $clog2(FLAGS)
);
    logic [FLGID_WIDTH-1:0]                   op_flgid;
    logic [FLGPTN_WIDTH-1:0]                  set_flg_flgptn;
    logic                                     set_flg_valid;
    logic [FLGPTN_WIDTH-1:0]                  clr_flg_flgptn;
    logic                                     clr_flg_valid;
    logic [TSKID_WIDTH-1:0]                   wai_flg_tskid;
    logic                                     wai_flg_wfmode;
    logic [FLGPTN_WIDTH-1:0]                  wai_flg_waiptn;
    logic                                     wai_flg_valid;
    logic                                     wai_flg_ack;
    logic [TSKID_WIDTH-1:0]                   rel_wai_tskid;
    logic                                     rel_wai_valid;
    logic [TSKID_WIDTH-1:0]                   wakeup_tskid;
    logic [FLGPTN_WIDTH-1:0]                  wakeup_flgptn;
    logic                                     wakeup_valid;
    logic                                     wakeup_ready;
    logic [FLAGS-1:0][FLGPTN_WIDTH-1:0]       flg_flgptn;
    logic [TASKS-1:0]                         task_waiting;
    logic                                     busy;

    modport master (
        output op_flgid, set_flg_flgptn, set_flg_valid, clr_flg_flgptn, clr_flg_valid,
        output wai_flg_tskid, wai_flg_wfmode, wai_flg_waiptn, wai_flg_valid,
        output rel_wai_tskid, rel_wai_valid, wakeup_ready,
        input  wai_flg_ack, wakeup_tskid, wakeup_flgptn, wakeup_valid,
        input  flg_flgptn, task_waiting, busy
    );

    modport slave (
        input  op_flgid, set_flg_flgptn, set_flg_valid, clr_flg_flgptn, clr_flg_valid,
        input  wai_flg_tskid, wai_flg_wfmode, wai_flg_waiptn, wai_flg_valid,
        input  rel_wai_tskid, rel_wai_valid, wakeup_ready,
        output wai_flg_ack, wakeup_tskid, wakeup_flgptn, wakeup_valid,
        output flg_flgptn, task_waiting, busy
    );
endinterface

// File: rtl/jelly_rtos_flggrp.sv
// rtl/jelly_rtos_flggrp.sv - RTOS event-flag group with task wait queue (option macro: JELLY_RTOS_FLGGRP_CLR_EN)
module jelly_rtos_flggrp #(
    parameter int TASKS        = 16,
    parameter int FLAGS        = 4,
    parameter int FLGPTN_WIDTH = 32,
    parameter int TSKID_WIDTH  = $clog2(TASKS),
    parameter int FLGID_WIDTH  = $clog2(FLAGS),
    parameter logic [FLAGS-1:0][FLGPTN_WIDTH-1:0] INIT_FLGPTN = '0
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              cke,
    jelly_rtos_flggrp_if.slave bus
);

`ifdef JELLY_RTOS_FLGGRP_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic [FLAGS-1:0][FLGPTN_WIDTH-1:0] flg;
    logic [FLAGS-1:0][FLGPTN_WIDTH-1:0] flg_next;
    logic [TASKS-1:0]                   waiting;
    logic [TASKS-1:0][FLGID_WIDTH-1:0]  t_flgid;
    logic [TASKS-1:0]                   t_wfmode;
    logic [TASKS-1:0][FLGPTN_WIDTH-1:0] t_waiptn;

    logic [TASKS-1:0]        pending;
    logic [TSKID_WIDTH-1:0]  sel;
    logic                    sel_found;
    logic                    load_en;
    logic                    wv;
    logic [TSKID_WIDTH-1:0]  wt;
    logic [FLGPTN_WIDTH-1:0] wp;
    logic                    busy_r;

    logic                    wai_accept;
    logic                    wai_sat;
    logic                    wai_ack;
    logic                    wai_enq;
    logic                    rel_do;

    function automatic logic cond_met(input logic [FLGPTN_WIDTH-1:0] ptn,
                                      input logic [FLGPTN_WIDTH-1:0] waiptn,
                                      input logic                    mode);
        if (mode) begin
            return |(ptn & waiptn);
        end
        return (ptn & waiptn) == waiptn;
    endfunction

    // A new wait is judged against the registered pattern, so a same-cycle set is not seen yet
    always_comb begin
        wai_accept = bus.wai_flg_valid && (|bus.wai_flg_waiptn) && !waiting[bus.wai_flg_tskid];
        wai_sat    = cond_met(flg[bus.op_flgid], bus.wai_flg_waiptn, bus.wai_flg_wfmode);
        wai_ack    = cke && wai_accept && wai_sat;
        wai_enq    = cke && wai_accept && !wai_sat;
        rel_do     = bus.rel_wai_valid && waiting[bus.rel_wai_tskid];
        load_en    = !wv || bus.wakeup_ready;
    end

    // Satisfied waiters; a forced release or a clear-on-wake ack on the same flag suppresses them
    always_comb begin
        pending = '0;
        for (int t = 0; t < TASKS; t++) begin
            pending[t] = waiting[t] && cond_met(flg[t_flgid[t]], t_waiptn[t], t_wfmode[t]);
            if (rel_do && bus.rel_wai_tskid == TSKID_WIDTH'(t)) begin
                pending[t] = 1'b0;
            end
            if (CLR_EN && wai_ack && t_flgid[t] == bus.op_flgid) begin
                pending[t] = 1'b0;
            end
        end
    end

    // Lowest-numbered pending task wins the wakeup slot
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int i = TASKS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel       = TSKID_WIDTH'(i);
                sel_found = 1'b1;
            end
        end
    end

    // Flag update order: clear-on-wake, then the clear mask, then the set pattern
    always_comb begin
        flg_next = flg;
        for (int f = 0; f < FLAGS; f++) begin
            if (CLR_EN && ((load_en && sel_found && t_flgid[sel] == FLGID_WIDTH'(f)) ||
                           (wai_ack && bus.op_flgid == FLGID_WIDTH'(f)))) begin
                flg_next[f] = '0;
            end
            if (bus.clr_flg_valid && bus.op_flgid == FLGID_WIDTH'(f)) begin
                flg_next[f] = flg_next[f] & bus.clr_flg_flgptn;
            end
            if (bus.set_flg_valid && bus.op_flgid == FLGID_WIDTH'(f)) begin
                flg_next[f] = flg_next[f] | bus.set_flg_flgptn;
            end
        end
    end

    // State registers: patterns, wait queue and the wakeup output slot
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            flg      <= INIT_FLGPTN;
            waiting  <= '0;
            t_flgid  <= '0;
            t_wfmode <= '0;
            t_waiptn <= '0;
            wv       <= 1'b0;
            wt       <= '0;
            wp       <= '0;
            busy_r   <= 1'b0;
        end else if (cke) begin
            flg <= flg_next;
            if (load_en) begin
                wv <= sel_found;
                if (sel_found) begin
                    wt           <= sel;
                    wp           <= flg[t_flgid[sel]];
                    waiting[sel] <= 1'b0;
                end
            end
            if (rel_do) begin
                waiting[bus.rel_wai_tskid] <= 1'b0;
            end
            if (wai_enq) begin
                waiting[bus.wai_flg_tskid]  <= 1'b1;
                t_flgid[bus.wai_flg_tskid]  <= bus.op_flgid;
                t_wfmode[bus.wai_flg_tskid] <= bus.wai_flg_wfmode;
                t_waiptn[bus.wai_flg_tskid] <= bus.wai_flg_waiptn;
            end
            busy_r <= (|pending) || (load_en ? sel_found : wv);
        end
    end

    assign bus.wai_flg_ack   = wai_ack;
    assign bus.wakeup_valid  = wv;
    assign bus.wakeup_tskid  = wt;
    assign bus.wakeup_flgptn = wp;
    assign bus.flg_flgptn    = flg;
    assign bus.task_waiting  = waiting;
    assign bus.busy          = busy_r;

endmodule
